// File: rtl/alut_age_sweep.sv
//------------------------------------------------------------------------------
// alut_age_sweep
//   Address-table ageing engine: time base, single-entry age checks, aged-entry
//   sweep and invalidate-all sweep over a 2^ADDR_W entry table.
//   Optional feature macro: ALUT_AGE_CNT_EN (adds inval_cnt output).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alut_age_sweep #(
    parameter int ADDR_W = 8,
    parameter int TIME_W = 32,
    parameter int MAC_W  = 48,
    parameter int PORT_W = 2,
    localparam int DATA_W = 1 + TIME_W + PORT_W + MAC_W
) (
    input  logic              pclk,
    input  logic              p_reset,
    input  logic [1:0]        command,
    input  logic [7:0]        div_clk,
    input  logic [TIME_W-1:0] best_bfr_age,
    input  logic              check_age,
    input  logic              add_check_active,
    input  logic [TIME_W-1:0] last_accessed,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [TIME_W-1:0] curr_time,
    output logic [MAC_W-1:0]  lst_inv_addr,
    output logic [PORT_W-1:0] lst_inv_port,
    output logic              age_confirmed,
    output logic              age_ok,
    output logic              inval_in_prog,
    output logic              age_check_active,
    output logic              sweep_done
`ifdef ALUT_AGE_CNT_EN
    ,
    output logic [ADDR_W:0]   inval_cnt
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ_CHK = 3'd1;
    localparam logic [2:0] S_SW_RD   = 3'd2;
    localparam logic [2:0] S_SW_CHK  = 3'd3;
    localparam logic [2:0] S_SW_WR   = 3'd4;
    localparam logic [2:0] S_INV_ALL = 3'd5;

    localparam logic [1:0] c_CMD_ABORT    = 2'b01;
    localparam logic [1:0] c_CMD_INV_AGED = 2'b10;
    localparam logic [1:0] c_CMD_INV_ALL  = 2'b11;
    localparam logic [ADDR_W-1:0] c_PTR_MAX = '1;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_div_cnt;
    logic [TIME_W-1:0] r_time;
    logic [MAC_W-1:0]  r_lst_mac;
    logic [PORT_W-1:0] r_lst_port;
    logic              r_age_conf;
    logic              r_age_ok;
    logic              r_done;
    logic              r_in_prog;

    logic              w_abort;
    logic              w_ptr_last;
    logic              w_rd_valid;
    logic [TIME_W-1:0] w_rd_stamp;
    logic [PORT_W-1:0] w_rd_port;
    logic [MAC_W-1:0]  w_rd_mac;
    logic [TIME_W-1:0] w_rd_age;
    logic              w_rd_aged;
    logic [TIME_W-1:0] w_req_age;
    logic              w_sweep;
    logic              w_next_sweep;

    assign w_abort    = (command == c_CMD_ABORT);
    assign w_ptr_last = (r_ptr == c_PTR_MAX);
    assign w_rd_valid = mem_read_data[DATA_W-1];
    assign w_rd_stamp = mem_read_data[DATA_W-2 -: TIME_W];
    assign w_rd_port  = mem_read_data[MAC_W +: PORT_W];
    assign w_rd_mac   = mem_read_data[MAC_W-1:0];
    // Ages are modulo 2^TIME_W so a wrapped time base still yields the right distance.
    assign w_rd_age   = r_time - w_rd_stamp;
    assign w_rd_aged  = w_rd_valid && (w_rd_age >= best_bfr_age);
    assign w_req_age  = r_time - last_accessed;

    assign w_sweep = (r_state == S_SW_RD) || (r_state == S_SW_CHK) ||
                     (r_state == S_SW_WR) || (r_state == S_INV_ALL);
    assign w_next_sweep = (w_next_state == S_SW_RD) || (w_next_state == S_SW_CHK) ||
                          (w_next_state == S_SW_WR) || (w_next_state == S_INV_ALL);

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (command == c_CMD_INV_AGED) begin
                    w_next_state = S_SW_RD;
                end else if (command == c_CMD_INV_ALL) begin
                    w_next_state = S_INV_ALL;
                // A request still held while its result strobes is not a new request.
                end else if (check_age && add_check_active && !r_age_conf) begin
                    w_next_state = S_REQ_CHK;
                end
            end
            S_REQ_CHK: w_next_state = S_IDLE;
            S_SW_RD:   w_next_state = w_abort ? S_IDLE : S_SW_CHK;
            S_SW_CHK: begin
                if (w_abort || (!w_rd_aged && w_ptr_last)) begin
                    w_next_state = S_IDLE;
                end else if (w_rd_aged) begin
                    w_next_state = S_SW_WR;
                end else begin
                    w_next_state = S_SW_RD;
                end
            end
            S_SW_WR:   w_next_state = (w_abort || w_ptr_last) ? S_IDLE : S_SW_RD;
            S_INV_ALL: w_next_state = (w_abort || w_ptr_last) ? S_IDLE : S_INV_ALL;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr         = w_sweep ? r_ptr : '0;
        mem_write        = (r_state == S_SW_WR) || (r_state == S_INV_ALL);
        age_check_active = (r_state != S_IDLE);
    end

    assign mem_write_data = '0;
    assign curr_time      = r_time;
    assign lst_inv_addr   = r_lst_mac;
    assign lst_inv_port   = r_lst_port;
    assign age_confirmed  = r_age_conf;
    assign age_ok         = r_age_ok;
    assign inval_in_prog  = r_in_prog;
    assign sweep_done     = r_done;

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_ptr      <= '0;
            r_div_cnt  <= '0;
            r_time     <= '0;
            r_lst_mac  <= '0;
            r_lst_port <= '0;
            r_age_conf <= 1'b0;
            r_age_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_in_prog  <= 1'b0;
        end else begin
            if (r_div_cnt == div_clk) begin
                r_div_cnt <= '0;
                r_time    <= r_time + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if ((r_state == S_IDLE) && w_next_sweep) begin
                r_ptr <= '0;
            end else if (((r_state == S_SW_CHK) || (r_state == S_SW_WR)) &&
                         (w_next_state == S_SW_RD)) begin
                r_ptr <= r_ptr + 1'b1;
            end else if ((r_state == S_INV_ALL) && (w_next_state == S_INV_ALL)) begin
                r_ptr <= r_ptr + 1'b1;
            end

            // Entry identity is taken from the read data before the write clears it.
            if ((r_state == S_SW_CHK) && (w_next_state == S_SW_WR)) begin
                r_lst_mac  <= w_rd_mac;
                r_lst_port <= w_rd_port;
            end

            r_age_conf <= (r_state == S_REQ_CHK);
            r_age_ok   <= (r_state == S_REQ_CHK) && (w_req_age < best_bfr_age);
            r_done     <= w_sweep && (w_next_state == S_IDLE);
            r_in_prog  <= w_next_sweep;
        end
    end

`ifdef ALUT_AGE_CNT_EN
    logic [ADDR_W:0] r_inval_cnt;

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_inval_cnt <= '0;
        end else if ((r_state == S_IDLE) && (w_next_state == S_SW_RD)) begin
            r_inval_cnt <= '0;
        end else if (r_state == S_SW_WR) begin
            r_inval_cnt <= r_inval_cnt + 1'b1;
        end
    end

    assign inval_cnt = r_inval_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alut_age_sweep.sv
//------------------------------------------------------------------------------
// tb_alut_age_sweep
//   Directed and randomized checks of alut_age_sweep against a table-level model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alut_age_sweep;

    localparam int ADDR_W = 3;
    localparam int TIME_W = 8;
    localparam int MAC_W  = 48;
    localparam int PORT_W = 2;
    localparam int DATA_W = 1 + TIME_W + PORT_W + MAC_W;
    localparam int DEPTH  = 8;

    logic              pclk = 1'b0;
    logic              p_reset = 1'b1;
    logic [1:0]        command = 2'b00;
    logic [7:0]        div_clk = 8'd0;
    logic [TIME_W-1:0] best_bfr_age = 8'd10;
    logic              check_age = 1'b0;
    logic              add_check_active = 1'b0;
    logic [TIME_W-1:0] last_accessed = '0;
    logic [DATA_W-1:0] mem_read_data = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_write_data;
    logic [TIME_W-1:0] curr_time;
    logic [MAC_W-1:0]  lst_inv_addr;
    logic [PORT_W-1:0] lst_inv_port;
    logic              age_confirmed;
    logic              age_ok;
    logic              inval_in_prog;
    logic              age_check_active;
    logic              sweep_done;
`ifdef ALUT_AGE_CNT_EN
    logic [ADDR_W:0]   inval_cnt;
`endif

    alut_age_sweep #(
        .ADDR_W(ADDR_W), .TIME_W(TIME_W), .MAC_W(MAC_W), .PORT_W(PORT_W)
    ) dut (
        .pclk(pclk), .p_reset(p_reset), .command(command), .div_clk(div_clk),
        .best_bfr_age(best_bfr_age), .check_age(check_age),
        .add_check_active(add_check_active), .last_accessed(last_accessed),
        .mem_read_data(mem_read_data), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .curr_time(curr_time),
        .lst_inv_addr(lst_inv_addr), .lst_inv_port(lst_inv_port),
        .age_confirmed(age_confirmed), .age_ok(age_ok),
        .inval_in_prog(inval_in_prog), .age_check_active(age_check_active),
        .sweep_done(sweep_done)
`ifdef ALUT_AGE_CNT_EN
        , .inval_cnt(inval_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    // Table memory with one-cycle read latency, plus a log of every write.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] img [DEPTH];
    logic load_req = 1'b0;
    logic log_clr  = 1'b0;
    int   wr_count = 0;
    int   wr_addr [64];
    int   wr_cyc  [64];
    logic wr_nonzero = 1'b0;
    int   cyc = 0;

    always @(posedge pclk) begin
        if (p_reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge pclk) begin
        mem_read_data <= mem[mem_addr];
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = img[i];
        end else if (mem_write) begin
            mem[mem_addr] = mem_write_data;
        end
        if (log_clr) begin
            wr_count   = 0;
            wr_nonzero = 1'b0;
        end else if (mem_write) begin
            if (wr_count < 64) begin
                wr_addr[wr_count] = int'(mem_addr);
                wr_cyc[wr_count]  = cyc;
            end
            wr_count++;
            if (mem_write_data != '0) wr_nonzero = 1'b1;
        end
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state kept by the bench.
    int               exp_addrs[$];
    logic [MAC_W-1:0] exp_lst_mac  = '0;
    logic [PORT_W-1:0] exp_lst_port = '0;
    logic [MAC_W-1:0] cand_mac;
    logic [PORT_W-1:0] cand_port;

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 0);
        chk({tag, ".mem_write"}, 64'(mem_write), 0);
        chk({tag, ".mem_wdata"}, 64'(mem_write_data), 0);
        chk({tag, ".curr_time"}, 64'(curr_time), 0);
        chk({tag, ".lst_addr"}, 64'(lst_inv_addr), 0);
        chk({tag, ".lst_port"}, 64'(lst_inv_port), 0);
        chk({tag, ".age_conf"}, 64'(age_confirmed), 0);
        chk({tag, ".age_ok"}, 64'(age_ok), 0);
        chk({tag, ".in_prog"}, 64'(inval_in_prog), 0);
        chk({tag, ".active"}, 64'(age_check_active), 0);
        chk({tag, ".done"}, 64'(sweep_done), 0);
`ifdef ALUT_AGE_CNT_EN
        chk({tag, ".inval_cnt"}, 64'(inval_cnt), 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge pclk);
        p_reset = 1'b1; command = 2'b00; check_age = 1'b0; add_check_active = 1'b0;
        @(negedge pclk);
        chk_all_zero(tag);
        @(negedge pclk);
        p_reset = 1'b0;
        exp_lst_mac = '0; exp_lst_port = '0;
    endtask

    // Single age request; time base is cycle-accurate only with div_clk=0.
    task automatic age_req(input string tag, input logic [7:0] stamp, input logic exp_ok);
        check_age = 1'b1; add_check_active = 1'b1; last_accessed = stamp;
        @(negedge pclk);
        chk({tag, ".reqchk"}, 64'(age_check_active), 1);
        chk({tag, ".time"}, 64'(curr_time), 64'(cyc % 256));
        @(negedge pclk);
        chk({tag, ".conf"}, 64'(age_confirmed), 1);
        chk({tag, ".ok"}, 64'(age_ok), 64'(exp_ok));
        check_age = 1'b0; add_check_active = 1'b0;
        @(negedge pclk);
        chk({tag, ".conf_off"}, 64'(age_confirmed), 0);
    endtask

    // Builds a table image whose aged/in-date status has wide margins so the
    // time base advancing during the sweep cannot change any verdict.
    task automatic start_aged(input string tag, input logic [7:0] aged_mask,
                              input logic [7:0] valid_mask);
        int t0;
        int age;
        logic [7:0] st;
        logic [MAC_W-1:0] mac;
        logic [PORT_W-1:0] port;
        t0 = cyc;
        exp_addrs.delete();
        for (int i = 0; i < DEPTH; i++) begin
            age  = aged_mask[i] ? 130 + int'($urandom % 70) : int'($urandom % 60);
            st   = 8'(t0 - age);
            mac[47:32] = 16'($urandom);
            mac[31:0]  = $urandom;
            port = 2'($urandom);
            img[i] = {valid_mask[i], st, port, mac};
            if (valid_mask[i] && aged_mask[i]) begin
                exp_addrs.push_back(i);
                cand_mac  = mac;
                cand_port = port;
            end
        end
        load_req = 1'b1; log_clr = 1'b1;
        @(negedge pclk);
        load_req = 1'b0; log_clr = 1'b0; command = 2'b10;
        @(negedge pclk);
        command = 2'b00;
        chk({tag, ".in_prog"}, 64'(inval_in_prog), 1);
        chk({tag, ".start_addr"}, 64'(mem_addr), 0);
    endtask

    task automatic run_aged(input string tag, input logic [7:0] aged_mask,
                            input logic [7:0] valid_mask, input logic with_req);
        int n;
        start_aged(tag, aged_mask, valid_mask);
        if (with_req) begin
            check_age = 1'b1; add_check_active = 1'b1;
            last_accessed = 8'(cyc - 3);
        end
        n = 0;
        while (sweep_done !== 1'b1 && n < 100) begin
            if (with_req) chk({tag, ".no_early_conf"}, 64'(age_confirmed), 0);
            @(negedge pclk);
            n++;
        end
        chk({tag, ".done"}, 64'(sweep_done), 1);
        chk({tag, ".idle"}, 64'(age_check_active), 0);
        chk({tag, ".nwrites"}, 64'(wr_count), 64'(exp_addrs.size()));
        for (int k = 0; k < exp_addrs.size() && k < wr_count; k++)
            chk({tag, ".waddr"}, 64'(wr_addr[k]), 64'(exp_addrs[k]));
        chk({tag, ".wdata"}, 64'(wr_nonzero), 0);
        if (exp_addrs.size() > 0) begin
            exp_lst_mac  = cand_mac;
            exp_lst_port = cand_port;
        end
        chk({tag, ".lst_addr"}, 64'(lst_inv_addr), 64'(exp_lst_mac));
        chk({tag, ".lst_port"}, 64'(lst_inv_port), 64'(exp_lst_port));
`ifdef ALUT_AGE_CNT_EN
        chk({tag, ".inval_cnt"}, 64'(inval_cnt), 64'(exp_addrs.size()));
`endif
        @(negedge pclk);
        chk({tag, ".done_once"}, 64'(sweep_done), 0);
        chk({tag, ".in_prog_off"}, 64'(inval_in_prog), 0);
        if (with_req) begin
            chk({tag, ".req_after"}, 64'(age_check_active), 1);
            chk({tag, ".conf_wait"}, 64'(age_confirmed), 0);
            @(negedge pclk);
            chk({tag, ".conf"}, 64'(age_confirmed), 1);
            chk({tag, ".ok"}, 64'(age_ok), 1);
            check_age = 1'b0; add_check_active = 1'b0;
            @(negedge pclk);
            chk({tag, ".conf_off"}, 64'(age_confirmed), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Time base with divider 3: one tick every four cycles.
        div_clk = 8'd3;
        do_reset("rst0");
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk);
            chk("div3.time", 64'(curr_time), 64'(cyc / 4));
        end

        // Age boundary cases with best_bfr_age=10.
        div_clk = 8'd0; best_bfr_age = 8'd10;
        do_reset("rst1");
        repeat (4) @(negedge pclk);
        age_req("age_t5_s250", 8'd250, 1'b0);
        do_reset("rst2");
        repeat (4) @(negedge pclk);
        age_req("age_t5_s252", 8'd252, 1'b1);
        age_req("age9",   8'(cyc + 1 - 9),   1'b1);
        age_req("age10",  8'(cyc + 1 - 10),  1'b0);
        age_req("age11",  8'(cyc + 1 - 11),  1'b0);
        age_req("age0",   8'(cyc + 1),       1'b1);
        age_req("age255", 8'(cyc + 1 - 255), 1'b0);

        // Abort in IDLE does nothing.
        command = 2'b01;
        @(negedge pclk);
        command = 2'b00;
        chk("abort_idle.active", 64'(age_check_active), 0);
        @(negedge pclk);
        chk("abort_idle.done", 64'(sweep_done), 0);

        // Aged sweeps.
        best_bfr_age = 8'd100;
        run_aged("sw25", 8'b0010_0100, 8'hFF, 1'b0);
        for (int r = 0; r < 4; r++)
            run_aged("swrand", 8'($urandom), 8'($urandom), 1'b0);
        run_aged("swinvalid", 8'hFF, 8'b1010_1010, 1'b0);

        // Invalidate all.
        log_clr = 1'b1;
        @(negedge pclk);
        log_clr = 1'b0; command = 2'b11;
        @(negedge pclk);
        command = 2'b00;
        n = 0;
        while (sweep_done !== 1'b1 && n < 40) begin
            @(negedge pclk);
            n++;
        end
        chk("invall.done", 64'(sweep_done), 1);
        chk("invall.nwrites", 64'(wr_count), 8);
        for (int k = 0; k < 8 && k < wr_count; k++) begin
            chk("invall.addr", 64'(wr_addr[k]), 64'(k));
            chk("invall.consec", 64'(wr_cyc[k] - wr_cyc[0]), 64'(k));
        end
        chk("invall.wdata", 64'(wr_nonzero), 0);
        @(negedge pclk);
        chk("invall.done_once", 64'(sweep_done), 0);

        // Abort at pointer 3.
        start_aged("abort", 8'h00, 8'hFF);
        n = 0;
        while (mem_addr !== 3'd3 && n < 40) begin
            @(negedge pclk);
            n++;
        end
        chk("abort.reach3", 64'(mem_addr), 3);
        command = 2'b01;
        @(negedge pclk);
        command = 2'b00;
        chk("abort.idle", 64'(age_check_active), 0);
        chk("abort.done", 64'(sweep_done), 1);
        repeat (4) @(negedge pclk);
        chk("abort.nwrites", 64'(wr_count), 0);
        chk("abort.done_once", 64'(sweep_done), 0);

        // Age request held through a sweep.
        run_aged("swreq", 8'($urandom), 8'hFF, 1'b1);

        // Reset while writing, then restart.
        start_aged("rstwr", 8'b0000_0100, 8'hFF);
        n = 0;
        while (mem_write !== 1'b1 && n < 40) begin
            @(negedge pclk);
            n++;
        end
        chk("rstwr.write_addr", 64'(mem_addr), 2);
        p_reset = 1'b1;
        @(negedge pclk);
        chk_all_zero("rstwr");
        p_reset = 1'b0;
        exp_lst_mac = '0; exp_lst_port = '0;
        run_aged("after_rst", 8'($urandom), 8'($urandom), 1'b0);

        // Time base wraps 255 -> 0.
        do_reset("rst3");
        while (cyc < 255) @(negedge pclk);
        chk("wrap.255", 64'(curr_time), 255);
        @(negedge pclk);
        chk("wrap.0", 64'(curr_time), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
